// File: rtl/sel_mux_pipe.sv
// N-way operand select into a 1-cycle valid/ready stage with a 1-entry skid; SEL_HOLD_EN replays last good data on bad select.
// in_ready is registered (skid empty); head and skid hold under !out_ready, flush empties both.
module sel_mux_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        err_count
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] dat;
  } entry_t;

  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W+1)'(NUM_IN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  entry_t           head_q;
  entry_t           skid_q;
  entry_t           new_ent;
  logic             head_vld;
  logic             skid_vld;
  logic             accept;
  logic             drain;
  logic             sel_oob;
  logic [WIDTH-1:0] sel_dat;
  logic [WIDTH-1:0] oob_dat;

  assign in_ready = !skid_vld;
  assign accept   = in_valid && in_ready;
  assign drain    = head_vld && out_ready;
  assign sel_oob  = ({1'b0, sel} >= NUM_IN_L);

`ifdef SEL_HOLD_EN
  // Survives flush on purpose: it tracks what upstream last delivered, not what is buffered.
  logic [WIDTH-1:0] last_good_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_good_q <= '0;
    end else if (accept && !sel_oob) begin
      last_good_q <= sel_dat;
    end
  end

  assign oob_dat = last_good_q;
`else
  assign oob_dat = '0;
`endif

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_dat = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    new_ent     = '0;
    new_ent.err = sel_oob;
    new_ent.dat = sel_oob ? oob_dat : sel_dat;
  end

  // Accept with a full skid cannot occur since in_ready is low then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (accept) begin
      if (!head_vld || drain) begin
        head_q   <= new_ent;
        head_vld <= 1'b1;
      end else begin
        skid_q   <= new_ent;
        skid_vld <= 1'b1;
      end
    end else if (drain) begin
      if (skid_vld) begin
        head_q   <= skid_q;
        skid_vld <= 1'b0;
      end else begin
        head_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && sel_oob && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign out_data    = head_q.dat;
  assign out_sel_err = head_q.err;
  assign out_valid   = head_vld;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed vector table for sel_mux_pipe (5 x 8-bit inputs, 2-bit error counter) plus an async-reset sequence.
module tb_sel_mux_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] in_bus;
  logic [2:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [7:0]  out_data;
  logic        out_sel_err;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  err_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sel_mux_pipe #(.WIDTH(8), .NUM_IN(5), .SEL_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel_err(out_sel_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  typedef struct {
    logic       iv;
    logic [2:0] sel;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic       cd;   // compare data/err this row
    logic [7:0] d;
    logic       e;
    logic       ir;
    logic [1:0] cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

`ifdef SEL_HOLD_EN
  localparam logic [7:0] OOB_D = 8'h44;
`else
  localparam logic [7:0] OOB_D = 8'h00;
`endif

  function automatic vec_t mk(input logic iv, input logic [2:0] s, input logic ordy, input logic fl,
                              input logic ov, input logic cd, input logic [7:0] d, input logic e,
                              input logic ir, input logic [1:0] cnt);
    vec_t v;
    v.iv = iv; v.sel = s; v.ordy = ordy; v.fl = fl; v.ov = ov;
    v.cd = cd; v.d = d; v.e = e; v.ir = ir; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_bus = 40'h44_33_22_11_00; sel = '0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    //             iv sel ordy fl  ov cd data   e  ir cnt
    vt[0]  = mk(1, 0, 1, 0,  1, 1, 8'h00, 0, 1, 0);
    vt[1]  = mk(1, 1, 1, 0,  1, 1, 8'h11, 0, 1, 0);
    vt[2]  = mk(1, 2, 1, 0,  1, 1, 8'h22, 0, 1, 0);
    vt[3]  = mk(1, 3, 1, 0,  1, 1, 8'h33, 0, 1, 0);
    vt[4]  = mk(1, 4, 1, 0,  1, 1, 8'h44, 0, 1, 0);
    vt[5]  = mk(0, 0, 1, 0,  0, 0, 8'h00, 0, 1, 0);
    vt[6]  = mk(1, 1, 0, 0,  1, 1, 8'h11, 0, 1, 0);
    vt[7]  = mk(1, 2, 0, 0,  1, 1, 8'h11, 0, 0, 0);
    vt[8]  = mk(1, 3, 0, 0,  1, 1, 8'h11, 0, 0, 0);
    vt[9]  = mk(0, 0, 1, 0,  1, 1, 8'h22, 0, 1, 0);
    vt[10] = mk(0, 0, 1, 0,  0, 0, 8'h00, 0, 1, 0);
    vt[11] = mk(1, 4, 1, 0,  1, 1, 8'h44, 0, 1, 0);
    vt[12] = mk(1, 5, 1, 0,  1, 1, OOB_D, 1, 1, 1);
    vt[13] = mk(1, 6, 1, 0,  1, 1, OOB_D, 1, 1, 2);
    vt[14] = mk(1, 7, 1, 0,  1, 1, OOB_D, 1, 1, 3);
    vt[15] = mk(1, 5, 1, 0,  1, 1, OOB_D, 1, 1, 3);
    vt[16] = mk(1, 6, 1, 0,  1, 1, OOB_D, 1, 1, 3);
    vt[17] = mk(0, 0, 1, 0,  0, 0, 8'h00, 0, 1, 3);
    vt[18] = mk(1, 1, 0, 0,  1, 1, 8'h11, 0, 1, 3);
    vt[19] = mk(1, 2, 0, 0,  1, 1, 8'h11, 0, 0, 3);
    vt[20] = mk(1, 3, 0, 1,  0, 0, 8'h00, 0, 1, 3);
    vt[21] = mk(0, 0, 1, 0,  0, 0, 8'h00, 0, 1, 3);
    vt[22] = mk(0, 0, 1, 0,  0, 0, 8'h00, 0, 1, 3);
    vt[23] = mk(1, 3, 1, 1,  0, 0, 8'h00, 0, 1, 3);
    vt[24] = mk(0, 0, 1, 0,  0, 0, 8'h00, 0, 1, 3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_sel_err", 32'(out_sel_err), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      in_valid = vt[i].iv; sel = vt[i].sel; out_ready = vt[i].ordy; flush = vt[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].ov));
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].ir));
      check($sformatf("v%0d err_count", i), 32'(err_count), 32'(vt[i].cnt));
      if (vt[i].cd) begin
        check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].d));
        check($sformatf("v%0d out_sel_err", i), 32'(out_sel_err), 32'(vt[i].e));
      end
      if (i == 20 || i == 23)
        check($sformatf("v%0d flush holds out_data", i), 32'(out_data), 32'h11);
    end

    // Async reset while a bad-select entry is stalled at the head.
    in_valid = 1'b1; sel = 3'd6; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("stall out_valid", 32'(out_valid), 32'd1);
    check("stall out_sel_err", 32'(out_sel_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", 32'(out_valid), 32'd0);
    check("arst out_sel_err", 32'(out_sel_err), 32'd0);
    check("arst err_count", 32'(err_count), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd1);
    check("arst out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; sel = 3'd2; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post-rst out_valid", 32'(out_valid), 32'd1);
    check("post-rst out_data", 32'(out_data), 32'h22);
    check("post-rst err_count", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
